// File: rtl/fir_serial_sym_if.sv
// Sample/coefficient/result bundle for the folded symmetric FIR.
// The source side drives samples and coefficient writes; the filter side
// returns the handshake, results and the sticky error flag.
interface fir_serial_sym_if #(
  parameter int DW = 12,
  parameter int CW = 12,
  parameter int AW = 3,
  parameter int OW = 28
);
  logic          en;
  logic [DW-1:0] xin;
  logic          ready;
  logic          coe_we;
  logic [AW-1:0] coe_addr;
  logic [CW-1:0] coe_din;
  logic          valid;
  logic [OW-1:0] yout;
  logic          err;

  modport master (
    output en, xin, coe_we, coe_addr, coe_din,
    input  ready, valid, yout, err
  );

  modport slave (
    input  en, xin, coe_we, coe_addr, coe_din,
    output ready, valid, yout, err
  );
endinterface

// File: rtl/fir_serial_sym.sv
// Resource-folded symmetric FIR: one pre-adder, one multiplier and one
// accumulator are time-shared over the H = TAPS/2 coefficient pairs.
// One result per accepted sample; latency and sample spacing are H+3 cycles.
module fir_serial_sym #(
  parameter int DW   = 12,
  parameter int CW   = 12,
  parameter int TAPS = 16
) (
  input  logic            clk,
  input  logic            rstn,
  fir_serial_sym_if.slave bus
);
  localparam int H   = TAPS / 2;
  localparam int AW  = (H > 1) ? $clog2(H) : 1;
  localparam int OW  = DW + CW + 1 + $clog2(H);
  localparam int TW  = AW + 1;
  localparam int CYW = $clog2(H + 3);
  localparam int PW  = DW + CW + 1;

  localparam logic [CYW-1:0] CYC_ONE  = CYW'(1);
  localparam logic [CYW-1:0] CYC_TWO  = CYW'(2);
  localparam logic [CYW-1:0] CYC_H    = CYW'(H);
  localparam logic [CYW-1:0] CYC_H1   = CYW'(H + 1);
  localparam logic [CYW-1:0] CYC_LAST = CYW'(H + 2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [CYW-1:0]        cyc_q;
  logic signed [DW-1:0]  x_q [TAPS];
  logic signed [CW-1:0]  h_q [H];
  logic signed [DW:0]    pre_q;
  logic signed [PW-1:0]  prod_q;
  logic signed [OW-1:0]  acc_q;
  logic [OW-1:0]         yout_q;
  logic                  valid_q;
  logic                  err_q;

  logic                  last, ready, accept, coe_ok;
  logic                  pre_en, prod_en, acc_en, acc_ld;
  logic [AW-1:0]         k_pre, k_prod;
  logic [TW-1:0]         ia, ib;

  // Schedule decode: cyc_q holds (edge number - 1) relative to acceptance.
  // ready is also raised in the final RUN cycle so the next sample can be
  // taken on the same edge that writes yout, giving H+3 cycle spacing.
  always_comb begin
    last    = (state_q == RUN) && (cyc_q == CYC_LAST);
    ready   = (state_q == IDLE) || last;
    accept  = bus.en && ready;
    coe_ok  = {1'b0, bus.coe_addr} < TW'(H);
    pre_en  = (state_q == RUN) && (cyc_q < CYC_H);
    prod_en = (state_q == RUN) && (cyc_q >= CYC_ONE) && (cyc_q <= CYC_H);
    acc_en  = (state_q == RUN) && (cyc_q >= CYC_TWO) && (cyc_q <= CYC_H1);
    acc_ld  = (cyc_q == CYC_TWO);
    k_pre   = cyc_q[AW-1:0];
    k_prod  = AW'(cyc_q - CYC_ONE);
    ia      = {1'b0, k_pre};
    ib      = TW'(TAPS - 1) - ia;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Cycle counter within a computation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                        cyc_q <= '0;
    else if (accept)                  cyc_q <= '0;
    else if (state_q == RUN && !last) cyc_q <= cyc_q + CYC_ONE;
  end

  // Delay line: x[0] holds the newest sample.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < TAPS; i++) x_q[i] <= '0;
    end else if (accept) begin
      for (int unsigned i = TAPS - 1; i > 0; i--) x_q[i] <= x_q[i-1];
      x_q[0] <= bus.xin;
    end
  end

  // Coefficient store; writes only land while idle and in range.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < H; i++) h_q[i] <= '0;
    end else if (bus.coe_we && ready && coe_ok) begin
      h_q[bus.coe_addr] <= bus.coe_din;
    end
  end

  // Pre-add / multiply / accumulate pipeline over the pairs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pre_q  <= '0;
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      if (pre_en)  pre_q  <= (DW+1)'(x_q[ia]) + (DW+1)'(x_q[ib]);
      if (prod_en) prod_q <= PW'(pre_q) * PW'(h_q[k_prod]);
      if (acc_en)  acc_q  <= acc_ld ? OW'(prod_q) : acc_q + OW'(prod_q);
    end
  end

  // Result register, valid pulse and sticky error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      yout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= last;
      if (last) yout_q <= acc_q;
      if ((bus.en && !ready) || (bus.coe_we && (!ready || !coe_ok))) err_q <= 1'b1;
    end
  end

  assign bus.ready = ready;
  assign bus.valid = valid_q;
  assign bus.yout  = yout_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_fir_serial_sym.sv
// Scoreboard bench for fir_serial_sym (TAPS=16, DW=CW=12, OW=28).
module tb_fir_serial_sym;
  localparam int OW = 28;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fir_serial_sym_if #(.DW(12), .CW(12), .AW(3), .OW(OW)) bus ();

  fir_serial_sym #(.DW(12), .CW(12), .TAPS(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic signed [OW-1:0] exp;
    int unsigned          cyc;
    int                   tag;
  } exp_t;

  exp_t        sb [$];
  exp_t        mon_e;
  int unsigned cyc_n  = 0;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned n_pop   = 0;

  int imp_tbl [16] = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 7, 6, 5, 4, 3, 2, 1};
  int dc_tbl  [16] = '{100, 300, 600, 1000, 1500, 2100, 2800, 3600,
                       4400, 5100, 5700, 6200, 6600, 6900, 7100, 7200};

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(req));
    end
  endtask

  // Monitor: every valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rstn && bus.valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        n_pop++;
        check($sformatf("yout_tag%0d", mon_e.tag), bus.yout, mon_e.exp);
        check($sformatf("latency_tag%0d", mon_e.tag), OW'(cyc_n - mon_e.cyc), 11);
      end
    end
  end

  task automatic send(input logic signed [11:0] x, input logic signed [OW-1:0] exp,
                      input bit chk, input int tag, input bit cwe = 1'b0,
                      input logic [2:0] ca = 3'd0, input logic signed [11:0] cd = 12'sd0);
    int unsigned w = 0;
    @(negedge clk);
    while (!bus.ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    bus.en       = 1'b1;
    bus.xin      = x;
    bus.coe_we   = cwe;
    bus.coe_addr = ca;
    bus.coe_din  = cd;
    @(posedge clk);
    #1;
    if (chk) sb.push_back('{exp, cyc_n, tag});
    bus.en     = 1'b0;
    bus.coe_we = 1'b0;
  endtask

  task automatic set_coef(input logic [2:0] k, input logic signed [11:0] v);
    @(negedge clk);
    bus.coe_we   = 1'b1;
    bus.coe_addr = k;
    bus.coe_din  = v;
    @(posedge clk);
    #1;
    bus.coe_we = 1'b0;
  endtask

  task automatic drain();
    int unsigned w = 0;
    while ((sb.size() != 0 || !bus.ready) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0 || !bus.ready) check("drain_timeout", 0, 1);
  endtask

  task automatic load_ramp();
    for (int k = 0; k < 8; k++) set_coef(3'(k), 12'(k + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en = 1'b0; bus.xin = '0; bus.coe_we = 1'b0; bus.coe_addr = '0; bus.coe_din = '0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    check("rst_ready", bus.ready, 1);
    check("rst_valid", bus.valid, 0);
    check("rst_yout",  bus.yout,  0);
    check("rst_err",   bus.err,   0);

    // Impulse response with h[k]=k+1.
    load_ramp();
    for (int n = 0; n < 16; n++) send((n == 0) ? 12'sd1 : 12'sd0, imp_tbl[n], 1'b1, n);
    drain();

    // DC input of 100.
    for (int j = 0; j < 16; j++) send(12'sd100, dc_tbl[j], 1'b1, 100 + j);
    drain();
    check("dc_err", bus.err, 0);

    // Extremes: h=-2048, x=-2048; j newest samples replace history of 100.
    for (int k = 0; k < 8; k++) set_coef(3'(k), -12'sd2048);
    for (int j = 1; j <= 16; j++) send(-12'sd2048, OW'(2048 * (2148 * j - 1600)), 1'b1, 200 + j);
    drain();

    // Overrun: second strobe 3 cycles after acceptance is dropped.
    send(12'sd0, 62914560, 1'b1, 300);
    repeat (2) @(posedge clk);
    #1;
    bus.en = 1'b1; bus.xin = 12'sd777;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    send(12'sd0, 58720256, 1'b1, 301);
    drain();
    check("overrun_err", bus.err, 1);

    // Reset in the middle of a computation.
    send(12'sd5, 0, 1'b0, 400);
    repeat (5) @(posedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    check("midrst_ready", bus.ready, 1);
    check("midrst_valid", bus.valid, 0);
    check("midrst_yout",  bus.yout,  0);
    check("midrst_err",   bus.err,   0);
    repeat (20) @(negedge clk);
    load_ramp();
    for (int n = 0; n < 16; n++) send((n == 0) ? 12'sd1 : 12'sd0, imp_tbl[n], 1'b1, 500 + n);
    drain();

    // Coefficient reload: busy write rejected, idle write with en used at once.
    send(12'sd1, 1, 1'b1, 600);
    repeat (2) @(posedge clk);
    #1;
    bus.coe_we = 1'b1; bus.coe_addr = 3'd0; bus.coe_din = 12'sd5;
    @(posedge clk);
    #1;
    bus.coe_we = 1'b0;
    send(12'sd3, 17, 1'b1, 601, 1'b1, 3'd0, 12'sd5);
    drain();
    check("coe_busy_err", bus.err, 1);

    check("valid_count", OW'(n_pop), 68);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_serial_sym.md
# fir_serial_sym

Parametrised, resource-folded symmetric FIR filter: one pre-adder, one multiplier and one accumulator are time-shared across all coefficient pairs. Signed samples and signed, runtime-loadable coefficients. Sits between a sample source and a downstream consumer, one result per accepted sample. Generalises the fixed 16-tap / 12-bit serial low-pass to arbitrary even tap count and widths, and adds backpressure, coefficient loading and overrun reporting.

## Interface
- DW, 12, input sample width, signed two's complement
- CW, 12, coefficient width, signed two's complement
- TAPS, 16, filter length; even, >= 4; H = TAPS/2 coefficient pairs
- Derived (localparam): AW = clog2(H) (min 1); OW = DW+CW+1+clog2(H)

- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- en  in  1  sample strobe; accepted only when ready=1
- xin  in  DW  input sample
- ready  out  1  block idle, next sample can be accepted
- coe_we  in  1  coefficient write strobe
- coe_addr  in  AW  pair index k (0..H-1), sets h[k] = h[TAPS-1-k]
- coe_din  in  CW  coefficient value
- valid  out  1  one-cycle pulse, yout updated
- yout  out  OW  signed filter output, held until next valid
- err  out  1  sticky: sample dropped or coefficient write rejected

## Operation
- Reset: delay line x[0..TAPS-1]=0, coefficients=0, ready=1, valid=0, yout=0, err=0, FSM IDLE.
- FSM: IDLE -> RUN on en&&ready; RUN -> IDLE once the last accumulation is complete and yout is written.
- Acceptance: shift x[i+1]<=x[i], x[0]<=xin; x[0] is the newest sample.
- Pair k (k = 0..H-1, in order): pre = x[k] + x[TAPS-1-k] (DW+1 bits, sign-extended), prod = pre * h[k] (DW+CW+1 bits signed), acc accumulates in OW bits. No rounding or saturation; OW is sized so overflow cannot occur.
- y[n] = sum over k of h[k]*(x[n-k] + x[n-TAPS+1+k]).
- en while ready=0: sample dropped, delay line unchanged, err<=1.
- coe_we while ready=1: h[coe_addr]<=coe_din. If it coincides with acceptance, the new value is used for that sample.
- coe_we while ready=0: write dropped, err<=1.
- coe_addr >= H (non-power-of-two H): write ignored, err<=1.
- err clears only on reset.
- valid is produced for every accepted sample, including warm-up; there is no fill suppression.

## Timing
- Edge 0: acceptance edge (en&&ready sampled high); ready falls after it.
- Edges 1..H: pre-adder register loads pair 0..H-1.
- Edges 2..H+1: product register.
- Edges 3..H+2: accumulator; it loads at edge 3 and adds on every later edge.
- Edge H+3: yout<=acc, valid=1 for one cycle, ready=1 in the same cycle.
- Next sample can be accepted at edge H+3 while valid is high.
- Latency and minimum sample spacing are both H+3 cycles (11 for TAPS=16).
- Reset asserted mid-computation aborts it: no valid, everything returns to reset values, ready=1 on the first cycle after deassertion.

## Test plan
- Impulse: TAPS=16, h[k]=k+1, samples 1 then fifteen 0s spaced 11 cycles apart -> yout = 1,2,...,8,8,7,...,1 with exactly 16 valid pulses, each arriving 11 cycles after its acceptance edge.
- DC: h[k]=k+1, xin held at 100 for 16 samples -> the 16th output is 100*2*36 = 7200; err stays 0.
- Extremes: all h=-2048, all xin=-2048 for 16 samples -> final yout = 67108864 (fits in 28-bit OW), no wrap.
- Overrun: en pulsed again 3 cycles after an acceptance -> sample ignored, delay line unchanged, err=1, the pending output is still correct.
- Coefficient reload: write h[0]=5 while busy -> err=1 and the current output uses the old h[0]. Write h[0]=5 in IDLE together with en -> that output uses 5.
- Reset mid-run: rstn low at edge 5 of a computation -> no valid, yout=0, ready=1; the next impulse reproduces the first impulse output from zero history.
